// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load queue.
// Data words are numbered big-endian: data bit 0 is the MSB, bit DW-1 is the LSB.
// In the RTL the vectors are declared [DW-1:0], so data bit i is Verilog bit DW-1-i
// and the right-justified byte (data bits 56..63) is Verilog [7:0].
package wb_pkg;

  localparam int DW = 64;
  localparam int AW = 5;

  // Load size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // One queued load; live=0 means a younger ALU write superseded it
  typedef struct packed {
    logic          live;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } lq_entry_t;

  // Extend right-justified load data to a full register value
  function automatic logic [DW-1:0] ld_extend(input logic [1:0] size,
                                              input logic       sext,
                                              input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    case (size)
      SZ_B:    r = {{(DW-8){sext & d[7]}},   d[7:0]};
      SZ_H:    r = {{(DW-16){sext & d[15]}}, d[15:0]};
      SZ_W:    r = {{(DW-32){sext & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Circular FIFO of pending loads. Each entry carries a live bit that a
// younger ALU write to the same rd clears; cancelled entries keep their slot.
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  lq_entry_t     push_entry,
  input  logic          pop,
  input  logic          cancel_en,
  input  logic [AW-1:0] cancel_rd,
  output lq_entry_t     head,
  output logic [CW-1:0] count
);

  lq_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Entry storage: cancel matching entries, then write the pushed entry
  // (a same-edge push lands in a free slot, so it is never cancelled here)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].live <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel_en && (mem[i].rd == cancel_rd)) begin
          mem[i].live <= 1'b0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges the never-stalling ALU pipe and the queued load pipe
// into one registered register-file write, with ALU priority and WAW cancel.
//
// Load handshake: a load transfers at a rising edge where ld_valid and ld_ready
// are both 1. ld_ready depends only on the current occupancy (count < DEPTH),
// not on whether the queue pops at the same edge.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [1:0]    ld_size,
  input  logic          ld_sext,
  input  logic [DW-1:0] ld_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [CW-1:0] lq_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  lq_entry_t push_entry;
  lq_entry_t head;
  logic      push;
  logic      pop;
  logic      alu_kill;

  // An ALU write to a real register supersedes older loads to that register
  assign alu_kill = alu_valid && (alu_rd != '0);

  assign ld_ready = (lq_count < FULL_COUNT);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (lq_count != '0);

  // A load accepted alongside an ALU write to the same rd is older, so it is dead on arrival
  always_comb begin
    push_entry      = '0;
    push_entry.live = !(alu_kill && (ld_rd == alu_rd));
    push_entry.rd   = ld_rd;
    push_entry.data = ld_extend(ld_size, ld_sext, ld_data);
  end

  wb_load_queue #(.DEPTH(DEPTH)) u_lq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .cancel_en  (alu_kill),
    .cancel_rd  (alu_rd),
    .head       (head),
    .count      (lq_count)
  );

  // Write port register: ALU first, then queue head, else idle with address/data held
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (alu_valid) begin
      wr_en   <= (alu_rd != '0);
      wr_addr <= alu_rd;
      wr_data <= alu_data;
    end else if (pop) begin
      wr_en   <= head.live && (head.rd != '0);
      wr_addr <= head.rd;
      wr_data <= head.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule
